// File: rtl/smc_pkg.sv
// Shared types and constants for the SMC sequential controller.
// Holds the FSM encoding, widths, sentinels and the output weighting.
package smc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        OUT  = 2'd3
    } smc_state_t;

    localparam int VTH   = 1;
    localparam int TR_W  = 3;
    localparam int RES_W = 7;
    localparam int OUT_W = 10;

    localparam logic [RES_W-1:0] RES_MIN = 7'd0;
    localparam logic [RES_W-1:0] RES_MAX = 7'd127;

    typedef struct packed {
        logic [TR_W-1:0] w;
        logic [TR_W-1:0] vgs;
        logic [TR_W-1:0] vds;
    } smc_tr_t;

    // Weighted mean for current mode, plain sum for gm mode.
    function automatic logic [OUT_W-1:0] smc_weight(
        input logic [RES_W-1:0] a,
        input logic [RES_W-1:0] b,
        input logic [RES_W-1:0] c,
        input logic             cur
    );
        logic [11:0] s;
        if (cur) begin
            s = 12'd3 * 12'(a) + 12'd4 * 12'(b) + 12'd5 * 12'(c);
            return OUT_W'(s / 12'd12);
        end else begin
            s = 12'(a) + 12'(b) + 12'(c);
            return OUT_W'(s);
        end
    endfunction

endpackage

// File: rtl/smc_cell.sv
// Combinational transistor cell: drain current or transconductance.
// Full product is formed before the floor division by three.
module smc_cell
    import smc_pkg::*;
(
    input  logic [TR_W-1:0]  i_w,
    input  logic [TR_W-1:0]  i_vgs,
    input  logic [TR_W-1:0]  i_vds,
    input  logic             i_sel_current,
    output logic [RES_W-1:0] o_res
);

    logic [TR_W-1:0] w_ov;
    logic            w_triode;
    logic [9:0]      w_w10;
    logic [9:0]      w_ov10;
    logic [9:0]      w_vds10;
    logic [9:0]      w_i_tri;
    logic [9:0]      w_i_sat;
    logic [9:0]      w_gm;
    logic [9:0]      w_num;

    assign w_ov = (i_vgs > TR_W'(VTH)) ? i_vgs - TR_W'(VTH) : '0;
    assign w_triode = w_ov > i_vds;

    assign w_w10   = 10'(i_w);
    assign w_ov10  = 10'(w_ov);
    assign w_vds10 = 10'(i_vds);

    // Triode term is only selected when ov > V_DS, so it never goes negative.
    assign w_i_tri = w_w10 * (10'd2 * w_ov10 * w_vds10 - w_vds10 * w_vds10);
    assign w_i_sat = w_w10 * w_ov10 * w_ov10;
    assign w_gm    = 10'd2 * w_w10 * (w_triode ? w_vds10 : w_ov10);

    assign w_num = i_sel_current ? (w_triode ? w_i_tri : w_i_sat) : w_gm;
    assign o_res = RES_W'(w_num / 10'd3);

endmodule

// File: rtl/smc_seq_ctrl.sv
// Serial front end and scheduler for the SMC current calculator.
// One shared cell walks the stored group and keeps the three extremes.
module smc_seq_ctrl
    import smc_pkg::*;
#(
    parameter int NUM_TR = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [TR_W-1:0]  W,
    input  logic [TR_W-1:0]  V_GS,
    input  logic [TR_W-1:0]  V_DS,
    input  logic [1:0]       mode,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_n
);

    localparam int IDX_W = (NUM_TR > 1) ? $clog2(NUM_TR) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_TR - 1);

    smc_state_t       r_state;
    smc_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [1:0]       r_mode;
    smc_tr_t          r_store [NUM_TR];
    logic [RES_W-1:0] r_n0, r_n1, r_n2;
    logic [RES_W-1:0] w_n0, w_n1, w_n2;
    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_n;
    logic             w_ov_nxt;
    logic [OUT_W-1:0] w_on_nxt;
    logic             w_first;
    logic             w_load;
    logic             w_last;
    smc_tr_t          w_cur;
    logic [RES_W-1:0] w_res;

    assign w_first = (r_state == IDLE) && in_valid;
    assign w_load  = (r_state == LOAD) && in_valid;
    assign w_last  = (r_idx == LAST);
    assign w_cur   = r_store[r_idx];

    smc_cell u_cell (
        .i_w           (w_cur.w),
        .i_vgs         (w_cur.vgs),
        .i_vds         (w_cur.vds),
        .i_sel_current (r_mode[0]),
        .o_res         (w_res)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (in_valid) w_state_nxt = (NUM_TR == 1) ? CALC : LOAD;
            LOAD: if (in_valid && w_last) w_state_nxt = CALC;
            CALC: if (w_last) w_state_nxt = OUT;
            OUT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode: strobe and weighted value for the coming OUT cycle.
    always_comb begin
        w_ov_nxt = (w_state_nxt == OUT);
        w_on_nxt = '0;
        if (w_ov_nxt) w_on_nxt = smc_weight(w_n0, w_n1, w_n2, r_mode[0]);
    end

    // Output registers keep the pins free of input-to-output paths.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_n     <= '0;
        end else begin
            r_out_valid <= w_ov_nxt;
            r_out_n     <= w_on_nxt;
        end
    end

    assign out_valid = r_out_valid;
    assign out_n     = r_out_n;

    // Index counter: beat slot during loading, evaluation slot in CALC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_first) begin
            r_idx <= (NUM_TR == 1) ? '0 : IDX_W'(1);
        end else if (w_load || r_state == CALC) begin
            r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
        end else if (r_state == OUT) begin
            r_idx <= '0;
        end
    end

    // Parameter storage and first-beat mode latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= '0;
            for (int i = 0; i < NUM_TR; i++) r_store[i] <= '0;
        end else if (w_first) begin
            r_mode     <= mode;
            r_store[0] <= '{w: W, vgs: V_GS, vds: V_DS};
        end else if (w_load) begin
            r_store[r_idx] <= '{w: W, vgs: V_GS, vds: V_DS};
        end
    end

    // Sorted insertion; strict compares let earlier equal entries stay higher.
    always_comb begin
        w_n0 = r_n0;
        w_n1 = r_n1;
        w_n2 = r_n2;
        if (r_mode[1]) begin
            if (w_res > r_n0) begin
                w_n0 = w_res; w_n1 = r_n0; w_n2 = r_n1;
            end else if (w_res > r_n1) begin
                w_n1 = w_res; w_n2 = r_n1;
            end else if (w_res > r_n2) begin
                w_n2 = w_res;
            end
        end else if (w_res < r_n0) begin
            if (w_res > r_n1) begin
                w_n0 = w_res; w_n1 = r_n1; w_n2 = r_n2;
            end else if (w_res > r_n2) begin
                w_n0 = r_n1; w_n1 = w_res; w_n2 = r_n2;
            end else begin
                w_n0 = r_n1; w_n1 = r_n2; w_n2 = w_res;
            end
        end
    end

    // Sorted list: seeded with the sentinel at group start, updated in CALC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n0 <= '0;
            r_n1 <= '0;
            r_n2 <= '0;
        end else if (w_first) begin
            r_n0 <= mode[1] ? RES_MIN : RES_MAX;
            r_n1 <= mode[1] ? RES_MIN : RES_MAX;
            r_n2 <= mode[1] ? RES_MIN : RES_MAX;
        end else if (r_state == CALC) begin
            r_n0 <= w_n0;
            r_n1 <= w_n1;
            r_n2 <= w_n2;
        end
    end

endmodule

// File: tb/tb_smc_seq_ctrl.sv
// Directed bench for smc_seq_ctrl.
// Hand-computed groups, latency, reset abort and back-to-back cases.
module tb_smc_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] W, V_GS, V_DS;
    logic [1:0] mode;
    logic       out_valid;
    logic [9:0] out_n;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    logic [2:0] g_w [6];
    logic [2:0] g_g [6];
    logic [2:0] g_d [6];

    smc_seq_ctrl #(.NUM_TR(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .W         (W),
        .V_GS      (V_GS),
        .V_DS      (V_DS),
        .mode      (mode),
        .out_valid (out_valid),
        .out_n     (out_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (out_valid === 1'b1) pulses++;

    task automatic load_ref();
        g_w = '{3'd7, 3'd3, 3'd1, 3'd6, 3'd2, 3'd5};
        g_g = '{3'd7, 3'd4, 3'd1, 3'd3, 3'd5, 3'd2};
        g_d = '{3'd7, 3'd1, 3'd5, 3'd2, 3'd3, 3'd4};
    endtask

    task automatic load_same(input logic [2:0] w, g, d);
        for (int i = 0; i < 6; i++) begin
            g_w[i] = w; g_g[i] = g; g_d[i] = d;
        end
    endtask

    task automatic send_beat(input logic [2:0] w, g, d,
                             input logic [1:0] m);
        in_valid = 1'b1; W = w; V_GS = g; V_DS = d; mode = m;
        @(posedge clk); #1;
        in_valid = 1'b0; W = '0; V_GS = '0; V_DS = '0; mode = '0;
    endtask

    task automatic send_group(input logic [1:0] m0, mr,
                              input bit gaps);
        for (int i = 0; i < 6; i++) begin
            send_beat(g_w[i], g_g[i], g_d[i], (i == 0) ? m0 : mr);
            if (gaps && i < 5) repeat (1 + (i % 3)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_out(output int lat, output logic [9:0] v);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        v = out_n;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0;
        W = '0; V_GS = '0; V_DS = '0; mode = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", out_valid);
        end
        checks++;
        if (out_n !== 10'd0) begin
            errors++;
            $display("FAIL reset_n got %0d want 0", out_n);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_modes();
        logic [1:0] ms [4];
        int         ex [4];
        int         lat;
        logic [9:0] v;
        ms = '{2'b11, 2'b01, 2'b10, 2'b00};
        ex = '{27, 1, 40, 5};
        load_ref();
        for (int k = 0; k < 4; k++) begin
            send_group(ms[k], ms[k], 1'b0);
            wait_out(lat, v);
            checks++;
            if (v !== 10'(ex[k])) begin
                errors++;
                $display("FAIL mode%0d got %0d want %0d", k, v, ex[k]);
            end
            checks++;
            if (lat != 6) begin
                errors++;
                $display("FAIL lat_mode%0d got %0d want 6", k, lat);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || out_n !== 10'd0) begin
                errors++;
                $display("FAIL one_cycle%0d got %b/%0d want 0/0",
                         k, out_valid, out_n);
            end
        end
    endtask

    task automatic test_gaps();
        int         lat;
        logic [9:0] v;
        load_ref();
        send_group(2'b11, 2'b11, 1'b1);
        wait_out(lat, v);
        checks++;
        if (v !== 10'd27) begin
            errors++;
            $display("FAIL gaps_val got %0d want 27", v);
        end
        checks++;
        if (lat != 6) begin
            errors++;
            $display("FAIL gaps_lat got %0d want 6", lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mode_change();
        int         lat;
        logic [9:0] v;
        load_ref();
        send_group(2'b11, 2'b00, 1'b0);
        wait_out(lat, v);
        checks++;
        if (v !== 10'd27) begin
            errors++;
            $display("FAIL mode_change got %0d want 27", v);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int         lat;
        int         p0;
        logic [9:0] v;
        load_ref();
        p0 = pulses;
        send_group(2'b11, 2'b11, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_n !== 10'd0) begin
            errors++;
            $display("FAIL abort_calc got %b/%0d want 0/0",
                     out_valid, out_n);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) send_beat(g_w[i], g_g[i], g_d[i], 2'b11);
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (pulses != p0) begin
            errors++;
            $display("FAIL abort_pulses got %0d want %0d", pulses, p0);
        end
        send_group(2'b10, 2'b10, 1'b0);
        wait_out(lat, v);
        checks++;
        if (v !== 10'd40 || lat != 6) begin
            errors++;
            $display("FAIL after_abort got %0d/lat%0d want 40/lat6", v, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int         lat;
        int         p0;
        logic [9:0] v;
        load_ref();
        p0 = pulses;
        send_group(2'b11, 2'b11, 1'b0);
        wait_out(lat, v);
        checks++;
        if (v !== 10'd27) begin
            errors++;
            $display("FAIL b2b_first got %0d want 27", v);
        end
        @(posedge clk); #1;
        send_group(2'b01, 2'b01, 1'b0);
        wait_out(lat, v);
        checks++;
        if (v !== 10'd1 || lat != 6) begin
            errors++;
            $display("FAIL b2b_second got %0d/lat%0d want 1/lat6", v, lat);
        end
        send_beat(3'd7, 3'd7, 3'd7, 2'b11);
        for (int i = 0; i < 5; i++) send_beat(g_w[i], g_g[i], g_d[i], 2'b00);
        checks++;
        if (pulses != p0 + 2) begin
            errors++;
            $display("FAIL drop_early got %0d want %0d", pulses, p0 + 2);
        end
        send_beat(g_w[5], g_g[5], g_d[5], 2'b00);
        wait_out(lat, v);
        checks++;
        if (v !== 10'd5 || lat != 6) begin
            errors++;
            $display("FAIL drop_third got %0d/lat%0d want 5/lat6", v, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_extremes();
        int         lat;
        logic [9:0] v;
        load_same(3'd7, 3'd7, 3'd7);
        send_group(2'b11, 2'b11, 1'b0);
        wait_out(lat, v);
        checks++;
        if (v !== 10'd84) begin
            errors++;
            $display("FAIL max_current got %0d want 84", v);
        end
        @(posedge clk); #1;
        load_same(3'd1, 3'd1, 3'd7);
        send_group(2'b10, 2'b10, 1'b0);
        wait_out(lat, v);
        checks++;
        if (v !== 10'd0 || lat != 6) begin
            errors++;
            $display("FAIL zero_gm got %0d/lat%0d want 0/lat6", v, lat);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_modes();
        test_gaps();
        test_mode_change();
        test_reset_abort();
        test_back_to_back();
        test_extremes();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
